// File: rtl/bandai2003_host.sv
`default_nettype none
// ============================================================================
// Module   : bandai2003_host
// Purpose  : Host-side unlock-and-capture sequencer for a Bandai 2003
//            cartridge. Drives the two-step unlock address sequence, then
//            shifts in a W-bit serial frame (LSB first) from SI.
// Revision : 1.0 - initial release
// ============================================================================
module bandai2003_host #(
  parameter int          W        = 20,
  parameter logic [7:0]  ADDR_ACK = 8'h5A,
  parameter logic [7:0]  ADDR_NAK = 8'hA5,
  parameter logic [7:0]  ADDR_NIL = 8'h00,
  parameter logic [W-1:0] EXPECT  = 20'h14503
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic         SI,
  output logic [7:0]   ADDR,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] DATA,
  output logic         VALID,
  output logic         MATCH
);

  // Counter must reach W-1; one spare code keeps the width safe for any W.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    NAK  = 2'd2,
    RECV = 2'd3
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;

  // Sequencer: unlock addresses one cycle each, then W shift cycles.
  // ABORT outranks START and frame completion on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      ADDR    <= ADDR_NIL;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      VALID   <= 1'b0;
      DATA    <= '1;
      r_cnt   <= '0;
    end else begin
      DONE <= 1'b0;
      if (ABORT && (r_state != IDLE)) begin
        r_state <= IDLE;
        ADDR    <= ADDR_NIL;
        BUSY    <= 1'b0;
        VALID   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (START) begin
              r_state <= ACK;
              ADDR    <= ADDR_ACK;
              BUSY    <= 1'b1;
              VALID   <= 1'b0;
              r_cnt   <= '0;
            end
          end
          ACK: begin
            r_state <= NAK;
            ADDR    <= ADDR_NAK;
          end
          NAK: begin
            // Cartridge loads its frame on this edge; bit 0 is on SI next.
            r_state <= RECV;
            ADDR    <= ADDR_NIL;
          end
          RECV: begin
            // No start-bit hunting: the frame itself may begin with ones.
            DATA  <= {SI, DATA[W-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              r_state <= IDLE;
              BUSY    <= 1'b0;
              VALID   <= 1'b1;
              DONE    <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            ADDR    <= ADDR_NIL;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Match flag follows the captured frame directly.
  always_comb begin
    MATCH = VALID && (DATA == EXPECT);
  end

endmodule
`default_nettype wire

// File: tb/tb_bandai2003_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_bandai2003_host
// Purpose  : Scoreboard bench for bandai2003_host with a model cartridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bandai2003_host;

  localparam int W = 20;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic         ABORT = 1'b0;
  logic         SI;
  logic [7:0]   ADDR;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] DATA;
  logic         VALID;
  logic         MATCH;

  bandai2003_host dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SI(SI),
    .ADDR(ADDR), .BUSY(BUSY), .DONE(DONE), .DATA(DATA), .VALID(VALID),
    .MATCH(MATCH)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Model cartridge: after seeing 5A then A5 it loads its frame, LSB first.
  // Only the first unlock after a cartridge reset yields the real frame.
  logic         cart_fresh = 1'b1;
  logic         si_zero    = 1'b0;
  logic [7:0]   prev_addr  = 8'h00;
  logic [W-1:0] cart_sh    = '1;

  always @(posedge CLK) begin
    prev_addr <= ADDR;
    if (ADDR == 8'hA5 && prev_addr == 8'h5A) begin
      cart_sh    <= cart_fresh ? 20'h14503 : 20'hFFFFF;
      cart_fresh <= 1'b0;
    end else begin
      cart_sh <= {1'b1, cart_sh[W-1:1]};
    end
  end

  assign SI = si_zero ? 1'b0 : cart_sh[0];

  typedef struct {
    logic [W-1:0] data;
    logic         match;
    int           c0;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every DONE pulse must correspond to a queued expectation.
  always @(negedge CLK) begin
    if (RST && DONE) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_data",    32'(DATA),  32'(e.data));
        check("done_match",   32'(MATCH), 32'(e.match));
        check("done_valid",   32'(VALID), 32'd1);
        check("done_busy",    32'(BUSY),  32'd0);
        check("done_latency", 32'(cyc - e.c0), 32'd22);
      end
    end
  end

  // Issue START at E0 and check the unlock address sequence up to E2.
  task automatic start_txn(input bit push, input logic [W-1:0] d, input logic m);
    exp_t e;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    if (push) begin
      e.data = d; e.match = m; e.c0 = cyc;
      sb.push_back(e);
    end
    check("addr_e0", 32'(ADDR), 32'h5A);
    check("busy_e0", 32'(BUSY), 32'd1);
    check("valid_e0", 32'(VALID), 32'd0);
    @(negedge CLK);
    check("addr_e1", 32'(ADDR), 32'hA5);
    @(negedge CLK);
    check("addr_e2", 32'(ADDR), 32'h00);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  32'(ADDR),  32'h00);
    check({tag, "_busy"},  32'(BUSY),  32'd0);
    check({tag, "_done"},  32'(DONE),  32'd0);
    check({tag, "_valid"}, 32'(VALID), 32'd0);
    check({tag, "_data"},  32'(DATA),  32'hFFFFF);
    check({tag, "_match"}, 32'(MATCH), 32'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Fresh cartridge: real frame, match.
    start_txn(1, 20'h14503, 1'b1);
    wait_drain();
    check("after1_match", 32'(MATCH), 32'd1);

    // Locked cartridge: all ones, no match.
    start_txn(1, 20'hFFFFF, 1'b0);
    wait_drain();
    check("after2_valid", 32'(VALID), 32'd1);

    // SI held low throughout.
    si_zero = 1'b1;
    start_txn(1, 20'h00000, 1'b0);
    wait_drain();
    si_zero = 1'b0;

    // ABORT at E10: 7 ones shifted (E3..E9) into 00000 -> FE000.
    start_txn(0, '0, 1'b0);
    repeat (7) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_busy",  32'(BUSY),  32'd0);
    check("abort_addr",  32'(ADDR),  32'h00);
    check("abort_valid", 32'(VALID), 32'd0);
    check("abort_data",  32'(DATA),  32'hFE000);
    d0 = n_done;
    repeat (30) @(negedge CLK);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("abort_data_hold", 32'(DATA), 32'hFE000);

    // START pulsed at E5 while busy is ignored: exactly one DONE.
    d0 = n_done;
    start_txn(1, 20'hFFFFF, 1'b0);
    repeat (2) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_drain();
    repeat (30) @(negedge CLK);
    check("busy_start_dones", 32'(n_done - d0), 32'd1);
    check("busy_start_idle", 32'(BUSY), 32'd0);

    // ABORT in IDLE leaves VALID and DATA alone.
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    @(negedge CLK);
    check("idle_abort_valid", 32'(VALID), 32'd1);
    check("idle_abort_data",  32'(DATA),  32'hFFFFF);

    // Reset mid-transaction, then a fresh sequence with a reset cartridge.
    start_txn(0, '0, 1'b0);
    repeat (6) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_vals("midrst");
    cart_fresh = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_vals("midrst_hold");
    RST = 1'b1;
    @(negedge CLK);
    start_txn(1, 20'h14503, 1'b1);
    wait_drain();
    check("final_match", 32'(MATCH), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bandai2003_host.md
BANDAI2003_HOST -- requirements
Module: bandai2003_host

Interface
REQ-001 Parameter: W, 20, serial frame width in bits.
REQ-002 Parameter: ADDR_ACK, 8'h5A, first unlock address.
REQ-003 Parameter: ADDR_NAK, 8'hA5, second unlock address.
REQ-004 Parameter: ADDR_NIL, 8'h00, idle address.
REQ-005 Parameter: EXPECT, 20'h14503, expected frame (SYSTEM_CTRL1 bit-8 set pattern).
REQ-006 Port: CLK  in  1  clock; all state changes on posedge.
REQ-007 Port: RST  in  1  reset, asynchronous, active-low.
REQ-008 Port: START  in  1  single-cycle request to run one unlock-and-capture transaction.
REQ-009 Port: ABORT  in  1  cancel the transaction in flight.
REQ-010 Port: SI  in  1  serial data from cartridge; idles high; LSB first.
REQ-011 Port: ADDR  out  8  registered unlock address driven to cartridge.
REQ-012 Port: BUSY  out  1  high while a transaction is in flight.
REQ-013 Port: DONE  out  1  one-cycle pulse when a full frame has been captured.
REQ-014 Port: DATA  out  W  captured frame; bit 0 is the first bit received.
REQ-015 Port: VALID  out  1  DATA holds a complete frame from the latest transaction.
REQ-016 Port: MATCH  out  1  VALID and DATA == EXPECT.

Function
REQ-017 The FSM SHALL have states IDLE, ACK, NAK, RECV.
REQ-018 In IDLE, ADDR SHALL be ADDR_NIL and BUSY low.
REQ-019 On edge E0 with START high in IDLE: ADDR <= ADDR_ACK, state <= ACK, BUSY <= 1, VALID <= 0, bit counter <= 0.
REQ-020 At E1 (the edge after E0): ADDR <= ADDR_NAK, state <= NAK; each unlock address SHALL be held exactly one cycle.
REQ-021 At E2: ADDR <= ADDR_NIL, state <= RECV; the cartridge loads its frame on E2, so SI carries frame bit 0 after E2.
REQ-022 In RECV, at edges E3..E(2+W), the block SHALL shift in SI as DATA <= {SI, DATA[W-1:1]} and increment the counter; no start-bit detection is used, since the frame may begin with 1s.
REQ-023 At E(2+W) (E22 for W=20): state <= IDLE, BUSY <= 0, VALID <= 1, DONE pulses high for the following cycle only.
REQ-024 Start-to-DONE latency SHALL be W+2 cycles after the START edge.
REQ-025 START SHALL be ignored while BUSY.
REQ-026 ABORT in any non-IDLE state SHALL force state IDLE, ADDR ADDR_NIL, BUSY 0, VALID 0, DONE 0 on that edge; ABORT has priority over START and over completion on the same edge.
REQ-027 ABORT in IDLE SHALL have no effect, and VALID/DATA SHALL be held.
REQ-028 DATA SHALL change only during RECV and hold its value at all other times.
REQ-029 MATCH SHALL be combinational: VALID && (DATA == EXPECT).
REQ-030 A repeated transaction without cartridge reset SHALL be run identically; a locked cartridge returns all ones, so the block SHALL capture 20'hFFFFF with MATCH 0.

Reset
REQ-031 When RST is low, the block SHALL asynchronously force state IDLE, ADDR ADDR_NIL, BUSY 0, DONE 0, VALID 0, DATA all ones, counter 0.
REQ-032 RST asserted mid-transaction SHALL abort with the values in REQ-031; the first START after release SHALL begin a fresh sequence.

Verification
REQ-033 Paired with a model cartridge, freshly reset: START at E0 -> ADDR 5A at E0..E1, A5 at E1..E2, 00 afterwards; DONE at E22; DATA 20'h14503; MATCH 1.
REQ-034 Second START with the cartridge not reset -> DATA 20'hFFFFF, VALID 1, MATCH 0.
REQ-035 SI driven 0 throughout, START -> DATA 20'h00000, MATCH 0, latency exactly 22 cycles.
REQ-036 ABORT at E10 -> BUSY 0 and ADDR 00 next cycle, no DONE, VALID 0; DATA holds its partial shift value.
REQ-037 START pulsed at E5 while BUSY -> ignored, single DONE at E22.
REQ-038 RST low at E8 then released; START -> all outputs at REQ-031 values during reset, then full correct capture with MATCH 1, provided the cartridge is also reset.
